// File: rtl/shift_pkg.sv
// Shared encodings for the iterative barrel-shift controller and its step stage.
package shift_pkg;

    localparam int unsigned STEP_MAX = 3;
    localparam int unsigned STEP_W   = 2;
    localparam int unsigned OP_W     = 2;

    localparam logic [OP_W-1:0] OP_LSL = 2'b00;
    localparam logic [OP_W-1:0] OP_LSR = 2'b01;
    localparam logic [OP_W-1:0] OP_ASR = 2'b10;
    localparam logic [OP_W-1:0] OP_ROR = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/shift_step32.sv
// Combinational 32-bit shift stage moving 0..3 positions per pass for LSL/LSR/ASR/ROR.
module shift_step32
    import shift_pkg::*;
(
    input  logic [31:0]       d_in,
    input  logic [OP_W-1:0]   op,
    input  logic [STEP_W-1:0] s,
    output logic [31:0]       d_out
);

    logic [63:0] rot_c;

    always_comb begin
        d_out = d_in;
        rot_c = {d_in, d_in} >> s;
        case (op)
            OP_LSL:  d_out = d_in << s;
            OP_LSR:  d_out = d_in >> s;
            OP_ASR:  d_out = 32'($signed(d_in) >>> s);
            OP_ROR:  d_out = rot_c[31:0];
            default: d_out = d_in;
        endcase
    end

endmodule

// File: rtl/shift_seq_ctrl.sv
// Multi-cycle shift controller: walks a 3-position-per-cycle step stage until the
// latched amount is consumed, then presents the result with a one-cycle done pulse.
module shift_seq_ctrl
    import shift_pkg::*;
#(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned SHAMT_W = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [OP_W-1:0]    op,
    input  logic [WIDTH-1:0]   d_in,
    input  logic [SHAMT_W-1:0] shamt,
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   d_out
);

    state_t              state;
    state_t              state_next;
    logic                busy_next;
    logic                done_next;
    logic [WIDTH-1:0]    acc;
    logic [SHAMT_W-1:0]  rem;
    logic [OP_W-1:0]     op_r;
    logic [STEP_W-1:0]   step_c;
    logic                last_c;
    logic [WIDTH-1:0]    step_out_c;

    // Largest step the stage allows, or whatever remains on the final pass.
    always_comb begin
        step_c = (rem > SHAMT_W'(STEP_MAX)) ? STEP_W'(STEP_MAX) : rem[STEP_W-1:0];
        last_c = (rem <= SHAMT_W'(STEP_MAX));
    end

    shift_step32 u_step (
        .d_in  (acc),
        .op    (op_r),
        .s     (step_c),
        .d_out (step_out_c)
    );

    // State and registered handshake outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_next;
            busy  <= busy_next;
            done  <= done_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (start) state_next = ST_SHIFT;
            ST_SHIFT: if (last_c) state_next = ST_DONE;
            ST_DONE:  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // Outputs decoded from the upcoming state so they line up with it after the edge.
    always_comb begin
        busy_next = 1'b0;
        done_next = 1'b0;
        case (state_next)
            ST_SHIFT: busy_next = 1'b1;
            ST_DONE:  done_next = 1'b1;
            default:  ;
        endcase
    end

    // Operand capture, iterative shifting and result register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc   <= '0;
            rem   <= '0;
            op_r  <= '0;
            d_out <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        acc  <= d_in;
                        rem  <= shamt;
                        op_r <= op;
                    end
                end
                ST_SHIFT: begin
                    acc <= step_out_c;
                    rem <= rem - SHAMT_W'(step_c);
                    if (last_c) d_out <= step_out_c;
                end
                default: ;
            endcase
        end
    end

endmodule
